// File: rtl/mpu_load_pkg.sv
// Shared definitions for the matrix load unit.
// global_defs holds the matrix sizing; mpu_pkg holds the load FSM states,
// the MPU operation codes and the row-major element index helper.
// MPU_LOAD_SIZE_CHECK_EN adds the ERR state used for rejected requests.
package global_defs;
    localparam int FP              = 32;
    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = $clog2(M);
    localparam int NBITS           = $clog2(N);
    localparam int MATRIX_REG_SIZE = 3;
endpackage

package mpu_pkg;
    import global_defs::*;

    localparam int IDX_BITS = $clog2(M * N);
    localparam int IDX_WIDE = MBITS + NBITS + 2;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MUL   = 3'd5
    } mpu_operation_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
`ifdef MPU_LOAD_SIZE_CHECK_EN
        ST_ERR  = 2'd3,
`endif
        ST_DONE = 2'd2
    } mpu_load_state_t;

    // Row-major flat index i*n+j, computed wide enough to never overflow
    function automatic logic [IDX_BITS-1:0] elem_index(
        input logic [MBITS-1:0] i,
        input logic [NBITS-1:0] j,
        input logic [NBITS:0]   n
    );
        return IDX_BITS'(IDX_WIDE'(i) * IDX_WIDE'(n) + IDX_WIDE'(j));
    endfunction
endpackage

// File: rtl/mpu_load_index_gen.sv
// Row/column walker for the matrix load: holds the i/j counters, exposes
// the location of the next write and flags the final element (m-1, n-1).
module mpu_load_index_gen
    import global_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [MBITS:0]   m_size,
    input  logic [NBITS:0]   n_size,
    output logic [MBITS-1:0] i,
    output logic [NBITS-1:0] j,
    output logic [MBITS-1:0] next_i,
    output logic [NBITS-1:0] next_j,
    output logic             last
);
    logic row_end;

    // Detect the final column of a row and the final element of the matrix
    always_comb begin
        row_end = ({1'b0, j} == (n_size - 1'b1));
        last    = row_end && ({1'b0, i} == (m_size - 1'b1));
    end

    // Location of the next write: restart on clear, wrap j into i on advance
    always_comb begin
        next_i = i;
        next_j = j;
        if (clear) begin
            next_i = '0;
            next_j = '0;
        end else if (advance) begin
            if (row_end) begin
                next_j = '0;
                next_i = i + 1'b1;
            end else begin
                next_j = j + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
        end else begin
            i <= next_i;
            j <= next_j;
        end
    end
endmodule

// File: rtl/mpu_load.sv
// Matrix load unit: accepts a load request in IDLE, captures the source
// matrix, sizes and destination, then streams one element per cycle to the
// register file in row-major order and pulses ack when done.
// Optional feature macro: MPU_LOAD_SIZE_CHECK_EN (reject illegal sizes via
// ERR); without it sizes are saturated into 1..M / 1..N.
module mpu_load
    import global_defs::*;
    import mpu_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_en_in,
    input  logic [M*N-1:0][FP-1:0]          mem_load_element_in,
    input  logic [MBITS:0]                  mem_m_load_size_in,
    input  logic [NBITS:0]                  mem_n_load_size_in,
    input  logic [MATRIX_REG_SIZE-1:0]      mem_load_addr_in,
    output logic                            mem_load_error_out,
    output logic                            mem_load_ack_out,
    output logic                            reg_load_en_out,
    output logic [MATRIX_REG_SIZE-1:0]      reg_load_addr_out,
    output logic [FP-1:0]                   reg_load_element_out,
    output logic [MBITS-1:0]                reg_i_load_loc_out,
    output logic [NBITS-1:0]                reg_j_load_loc_out,
    output logic [MBITS:0]                  reg_m_load_size_out,
    output logic [NBITS:0]                  reg_n_load_size_out
);
    localparam logic [MBITS:0] M_MAX = (MBITS + 1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS + 1)'(N);

    mpu_load_state_t              state, next_state;
    logic                         accept;
    logic                         advance;
    logic [M*N-1:0][FP-1:0]       matrix_q;
    logic [MBITS:0]               m_q, m_cap;
    logic [NBITS:0]               n_q, n_cap;
    logic [MATRIX_REG_SIZE-1:0]   addr_q;
    logic [MBITS-1:0]             cur_i, next_i;
    logic [NBITS-1:0]             cur_j, next_j;
    logic                         last;
    logic                         load_en_d;
    logic                         ack_d;
    logic [FP-1:0]                element_d;
`ifdef MPU_LOAD_SIZE_CHECK_EN
    logic                         request_legal;
    logic                         err_d;
`endif

    // Condition the requested sizes before they are captured
    always_comb begin
`ifdef MPU_LOAD_SIZE_CHECK_EN
        m_cap = mem_m_load_size_in;
        n_cap = mem_n_load_size_in;
        request_legal = (mem_m_load_size_in != '0) && (mem_n_load_size_in != '0) &&
                        (mem_m_load_size_in <= M_MAX) && (mem_n_load_size_in <= N_MAX);
`else
        if (mem_m_load_size_in == '0)
            m_cap = (MBITS + 1)'(1);
        else if (mem_m_load_size_in > M_MAX)
            m_cap = M_MAX;
        else
            m_cap = mem_m_load_size_in;
        if (mem_n_load_size_in == '0)
            n_cap = (NBITS + 1)'(1);
        else if (mem_n_load_size_in > N_MAX)
            n_cap = N_MAX;
        else
            n_cap = mem_n_load_size_in;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load_en_in) begin
                    accept = 1'b1;
`ifdef MPU_LOAD_SIZE_CHECK_EN
                    next_state = request_legal ? ST_LOAD : ST_ERR;
`else
                    next_state = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                if (last)
                    next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
`ifdef MPU_LOAD_SIZE_CHECK_EN
            ST_ERR:  next_state = ST_IDLE;
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    assign advance = (state == ST_LOAD) && !last;

    mpu_load_index_gen u_index_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance (advance),
        .m_size  (m_q),
        .n_size  (n_q),
        .i       (cur_i),
        .j       (cur_j),
        .next_i  (next_i),
        .next_j  (next_j),
        .last    (last)
    );

    // Output values for the coming cycle, aligned with the next state
    always_comb begin
        load_en_d = (next_state == ST_LOAD);
        ack_d     = (next_state == ST_DONE);
        element_d = '0;
        if (load_en_d)
            element_d = accept ? mem_load_element_in[0]
                               : matrix_q[elem_index(next_i, next_j, n_q)];
`ifdef MPU_LOAD_SIZE_CHECK_EN
        err_d = (next_state == ST_ERR);
`endif
    end

    // Capture the request so later input changes cannot disturb the load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            matrix_q <= '0;
            m_q      <= '0;
            n_q      <= '0;
            addr_q   <= '0;
        end else if (accept) begin
            matrix_q <= mem_load_element_in;
            m_q      <= m_cap;
            n_q      <= n_cap;
            addr_q   <= mem_load_addr_in;
        end
    end

    // Registered strobe, ack and data outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_load_en_out      <= 1'b0;
            mem_load_ack_out     <= 1'b0;
            reg_load_element_out <= '0;
        end else begin
            reg_load_en_out      <= load_en_d;
            mem_load_ack_out     <= ack_d;
            reg_load_element_out <= element_d;
        end
    end

`ifdef MPU_LOAD_SIZE_CHECK_EN
    // Registered reject pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_load_error_out <= 1'b0;
        else
            mem_load_error_out <= err_d;
    end
`else
    assign mem_load_error_out = 1'b0;
`endif

    assign reg_load_addr_out   = addr_q;
    assign reg_m_load_size_out = m_q;
    assign reg_n_load_size_out = n_q;
    assign reg_i_load_loc_out  = cur_i;
    assign reg_j_load_loc_out  = cur_j;
endmodule

// File: tb/tb_mpu_load.sv
// Directed testbench for mpu_load: reset, NOP, 2x2 / 1xN / Mx1 / 3x2 / 4x4
// loads, held request, size rejection or saturation, reset mid-load.
// Cycle k means the cycle after the k-th rising edge following acceptance.
module tb_mpu_load;
    import global_defs::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        load_en;
    logic [M*N-1:0][FP-1:0]      mem_elem;
    logic [MBITS:0]              mem_m;
    logic [NBITS:0]              mem_n;
    logic [MATRIX_REG_SIZE-1:0]  mem_addr;
    logic                        err_out;
    logic                        ack_out;
    logic                        wr_en;
    logic [MATRIX_REG_SIZE-1:0]  wr_addr;
    logic [FP-1:0]               wr_data;
    logic [MBITS-1:0]            wr_i;
    logic [NBITS-1:0]            wr_j;
    logic [MBITS:0]              wr_m;
    logic [NBITS:0]              wr_n;

    int total_checks  = 0;
    int passed_checks = 0;
    logic [FP-1:0] exp_mat [M*N];

    always #5 clk = ~clk;

    mpu_load dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_en_in           (load_en),
        .mem_load_element_in  (mem_elem),
        .mem_m_load_size_in   (mem_m),
        .mem_n_load_size_in   (mem_n),
        .mem_load_addr_in     (mem_addr),
        .mem_load_error_out   (err_out),
        .mem_load_ack_out     (ack_out),
        .reg_load_en_out      (wr_en),
        .reg_load_addr_out    (wr_addr),
        .reg_load_element_out (wr_data),
        .reg_i_load_loc_out   (wr_i),
        .reg_j_load_loc_out   (wr_j),
        .reg_m_load_size_out  (wr_m),
        .reg_n_load_size_out  (wr_n)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_checks++;
        if (observed === expected)
            passed_checks++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic en, input int m, input int n, input int addr);
        load_en  = en;
        mem_m    = (MBITS + 1)'(m);
        mem_n    = (NBITS + 1)'(n);
        mem_addr = MATRIX_REG_SIZE'(addr);
        for (int k = 0; k < M * N; k++)
            mem_elem[k] = exp_mat[k];
    endtask

    task automatic scrambleInputs();
        for (int k = 0; k < M * N; k++)
            mem_elem[k] = ~exp_mat[k];
        mem_m    = (MBITS + 1)'(1);
        mem_n    = (NBITS + 1)'(1);
        mem_addr = ~mem_addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput(tag, {61'd0, wr_en, ack_out, err_out}, 64'd0);
    endtask

    // Full load: me x ne writes in cycles 1..me*ne, ack in cycle me*ne+1
    task automatic doLoad(input int m, input int n, input int addr, input bit hold);
        int me, ne;
        me = (m == 0) ? 1 : ((m > M) ? M : m);
        ne = (n == 0) ? 1 : ((n > N) ? N : n);
        applyStimulus(1'b1, m, n, addr);
        step();
        if (!hold) begin
            load_en = 1'b0;
            scrambleInputs();
        end
        for (int k = 0; k < me * ne; k++) begin
            checkOutput("wr_en",   wr_en, 1);
            checkOutput("wr_row",  wr_i, k / ne);
            checkOutput("wr_col",  wr_j, k % ne);
            checkOutput("wr_data", wr_data, exp_mat[k]);
            checkOutput("wr_addr", wr_addr, addr);
            checkOutput("wr_no_ack_err", {ack_out, err_out}, 0);
            step();
        end
        checkOutput("ack",       ack_out, 1);
        checkOutput("ack_no_wr", {wr_en, err_out}, 0);
        checkOutput("m_size",    wr_m, me);
        checkOutput("n_size",    wr_n, ne);
        step();
        checkOutput("ack_pulse", ack_out, 0);
        checkOutput("m_size_hold", wr_m, me);
        checkOutput("addr_hold",   wr_addr, addr);
    endtask

`ifdef MPU_LOAD_SIZE_CHECK_EN
    // Illegal request: error in cycle 1, then nothing
    task automatic doReject(input int m, input int n);
        applyStimulus(1'b1, m, n, 1);
        step();
        load_en = 1'b0;
        checkOutput("err_pulse", err_out, 1);
        checkOutput("err_no_wr_ack", {wr_en, ack_out}, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            checkQuiet("err_after");
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        bit seen;
        exp_mat[0] = 32'h3f800000;
        exp_mat[1] = 32'h424951ec;
        exp_mat[2] = 32'hc0200000;
        exp_mat[3] = 32'h3e000000;
        for (int k = 4; k < M * N; k++)
            exp_mat[k] = 32'h4000_0000 + 32'(k) * 32'h0011_0101;

        rst = 1'b0;
        applyStimulus(1'b0, 0, 0, 0);
        #2;
        checkOutput("reset_outputs", {wr_en, ack_out, err_out, wr_addr, wr_data, wr_i, wr_j}, 0);
        checkOutput("reset_sizes", {wr_m, wr_n}, 0);
        #10;
        rst = 1'b1;
        step();

        $display("[TB] NOP for 10 cycles");
        for (int c = 0; c < 10; c++) begin
            step();
            checkQuiet("nop");
        end

        $display("[TB] 2x2 load to addr 0");
        doLoad(2, 2, 0, 1'b0);
        $display("[TB] 1xN and Mx1 loads to addr 1");
        doLoad(1, N, 1, 1'b0);
        doLoad(M, 1, 1, 1'b0);
        $display("[TB] 3x2 and full loads");
        doLoad(3, 2, 5, 1'b0);
        doLoad(M, N, 6, 1'b0);

        $display("[TB] load_en held high through a 2x2 load");
        doLoad(2, 2, 3, 1'b1);
        checkOutput("hold_idle_no_wr", wr_en, 0);
        step();
        checkOutput("hold_reaccept", wr_en, 1);
        checkOutput("hold_reaccept_loc", {wr_i, wr_j}, 0);
        load_en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            seen = ack_out;
        end
        checkOutput("hold_drain_ack", seen, 1);
        step();

`ifdef MPU_LOAD_SIZE_CHECK_EN
        $display("[TB] illegal sizes rejected");
        doReject(0, 2);
        doReject(M + 1, 1);
        doReject(1, 0);
`else
        $display("[TB] out-of-range sizes saturated");
        doLoad(0, 2, 1, 1'b0);
        doLoad(M + 3, N + 1, 2, 1'b0);
`endif

        $display("[TB] reset in the middle of a 2x2 load");
        applyStimulus(1'b1, 2, 2, 2);
        step();
        load_en = 1'b0;
        step();
        checkOutput("pre_reset_wr", {wr_en, wr_data}, {1'b1, 32'h424951ec});
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {wr_en, ack_out, err_out, wr_addr, wr_data, wr_i, wr_j}, 0);
        checkOutput("async_reset_sizes", {wr_m, wr_n}, 0);
        #3;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checkQuiet("post_reset_quiet");
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
